instr_issue_sequencer: RTL

- Sits directly upstream of the datapath top level. Buffers 32-bit instruction words arriving on a valid/ready stream in a small FIFO.
- Decodes each word into the 5-bit opcode and the 10-bit address fields the datapath consumes.
- Presents each decoded instruction, held stable, for a programmable number of cycles. Counts issued instructions and flags malformed words.

---
 rtl/instr_issue_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instr_issue_sequencer.sv
// Instruction issue sequencer: buffers 32-bit words, decodes them and
// presents each decoded instruction to the datapath for a fixed hold time.
`timescale 1ns/1ps
module instr_issue_sequencer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [31:0]                 instr_in,
   input  logic                        instr_valid,
   output logic                        instr_ready,
   input  logic                        stall,
   output logic [4:0]                  opcode,
   output logic [9:0]                  read_address,
   output logic [9:0]                  read_address_reg,
   output logic [9:0]                  reg1,
   output logic [9:0]                  address_mem,
   output logic [9:0]                  write_address,
   output logic [9:0]                  write_address_reg,
   output logic [9:0]                  reg2,
   output logic [9:0]                  address_alu,
   output logic [9:0]                  address_to_mem,
   output logic                        issue_valid,
   output logic                        issue_first,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0]                 issued_count,
   output logic                        illegal_seen
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_e;

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;

   state_e        state_q, state_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic [4:0]    opcode_q, opcode_d;
   logic [9:0]    field_a_q, field_a_d;
   logic [9:0]    field_b_q, field_b_d;
   logic          first_q, first_d;
   logic [15:0]   count_q, count_d;
   logic          illegal_q, illegal_d;

   logic          push;
   logic          pop;
   logic          hold_done;
   logic [31:0]   head;
   logic          head_legal;

   assign instr_ready = (level_q != LEVEL_FULL);
   assign push        = instr_valid & instr_ready;
   assign head        = mem_q[rd_ptr_q];
   assign head_legal  = (head[6:0] == 7'd0);
   assign hold_done   = (state_q == PRESENT) && (hold_cnt_q == HOLD_LAST);
   assign pop         = ((state_q == IDLE) || hold_done) &&
                        (level_q != '0) && !stall;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      opcode_d   = opcode_q;
      field_a_d  = field_a_q;
      field_b_d  = field_b_q;
      first_d    = 1'b0;
      count_d    = count_q;
      illegal_d  = illegal_q;
      if (pop) begin
         if (head_legal) begin
            state_d    = PRESENT;
            hold_cnt_d = '0;
            opcode_d   = head[31:27];
            field_a_d  = head[26:17];
            field_b_d  = head[16:7];
            first_d    = 1'b1;
            count_d    = count_q + 16'd1;
         end else begin
            // malformed word is dropped; addresses keep their last values
            state_d   = IDLE;
            opcode_d  = 5'd0;
            illegal_d = 1'b1;
         end
      end else if ((state_q == PRESENT) && !stall) begin
         if (hold_done) begin
            state_d  = IDLE;
            opcode_d = 5'd0;
         end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
         end
      end
   end

   // storage is not reset: the pointers alone define valid contents
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= instr_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         opcode_q   <= '0;
         field_a_q  <= '0;
         field_b_q  <= '0;
         first_q    <= 1'b0;
         count_q    <= '0;
         illegal_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         opcode_q   <= opcode_d;
         field_a_q  <= field_a_d;
         field_b_q  <= field_b_d;
         first_q    <= first_d;
         count_q    <= count_d;
         illegal_q  <= illegal_d;
      end
   end

   assign opcode            = opcode_q;
   assign read_address      = field_a_q;
   assign read_address_reg  = field_a_q;
   assign reg1              = field_a_q;
   assign address_mem       = field_a_q;
   assign write_address     = field_b_q;
   assign write_address_reg = field_b_q;
   assign reg2              = field_b_q;
   assign address_alu       = field_b_q;
   assign address_to_mem    = field_b_q;
   assign issue_valid       = (state_q == PRESENT);
   assign issue_first       = first_q;
   assign fifo_level        = level_q;
   assign issued_count      = count_q;
   assign illegal_seen      = illegal_q;

endmodule
